segasys1_sprcoll_ram: RTL and testbench
=======================================

// Module: segasys1_sprcoll_ram
// PURPOSE
// - Responder/storage end of the sprite-collision report (sprcoll pulse + sprcoll_ad) from the sprite line renderer.
// - Holds a 1024 x 1 collision matrix and a summary flag, both visible to the Z80 bus.
// - The CPU reads and clears them through the collision RAM window (F800-FBFF entries, FC00 summary in the system map).
// - Sits between the sprite renderer and the CPU data-bus mux.
// PARAMETERS
// - QDEPTH  4   set-request queue depth (power of 2, >=2)
// - AW      10  matrix address width ({spr_num[4:0], other_spr[4:0]})
// PORTS
// - VCLKx4    in   1   sole clock; all logic on posedge
// - RSTn      in   1   asynchronous, active-low reset
// - sprcoll   in   1   collision strobe from renderer; high >=1 clk, min 2 clk apart
// - sprcoll_ad in  AW  matrix address; valid while sprcoll high
// - cpu_cs    in   1   collision window select
// - cpu_rd    in   1   read strobe (qualified by cpu_cs)
// - cpu_wr    in   1   write strobe (qualified by cpu_cs); data ignored, write = clear
// - cpu_ad    in   11  [10]=0 matrix entry cpu_ad[9:0]; [10]=1 summary/status
// - cpu_dout  out  8   read data, registered
// - busy      out  1   high during init sweep
// BEHAVIOUR
// - One clock (VCLKx4); asynchronous active-low reset RSTn.
// - Reset values: cpu_dout=8'h00, busy=1, summary=0, ovf=0, queue empty, FSM=INIT, sweep addr=0.
// - Matrix storage: single-write-port RAM, not reset; contents cleared by the INIT sweep.
// - FSM INIT: writes 0 to addr 0..1023, one per clk; busy=1; sprcoll ignored; CPU reads return 00; CPU writes ignored.
// - INIT -> RUN after addr 1023 is written (1024 clks after RSTn rise); busy falls on the same edge.
// - RSTn asserted in any state -> INIT with the queue flushed; the sweep restarts at 0.
// - Edge detect: event = sprcoll & ~sprcoll_q. A multi-clk pulse counts once; sprcoll_ad is captured on the rising clk.
// - RUN event: push sprcoll_ad into the set queue and set summary=1 on that same edge.
// - Queue full at event: drop the request and set sticky ovf=1. Summary is still set.
// - Write-port arbitration, per clk:
//   1) CPU matrix clear (cpu_cs&cpu_wr&~cpu_ad[10]) writes 0 at cpu_ad[9:0];
//   2) otherwise pop the queue head and write 1.
// - A CPU write holding the port stalls the pop; pops resume the next clk.
// - Clear of addr X while a set for X is still queued: the queued set lands afterwards, and the entry reads 1.
// - Push and pop in the same clk are legal at any occupancy (count unchanged). Push while full is dropped even if a pop happens that clk.
// - CPU summary write (cpu_ad[10]=1): summary<=0 and ovf<=0. An event on the same clk wins: summary=1.
// - CPU read, 1 clk latency:
//   - matrix: cpu_dout={7'b0, entry};
//   - summary: cpu_dout={6'b0, ovf, summary}.
// - cpu_dout holds its value until the next read.
// - A read of an entry written on the same clk returns the old value.
// - cpu_rd and cpu_wr both high: the write is performed and the read data is the pre-write value.
// CONFIGURATION
// - SPRCOLL_SYM_EN defined: each accepted event enqueues two sets, {a,b} and {b,a} (a=ad[9:5], b=ad[4:0]).
//   - Both are pushed the same clk; an event needs 2 free slots, otherwise the whole event is dropped (ovf=1).
//   - a==b enqueues a single set.
// - SPRCOLL_SYM_EN undefined: one set per event, address as given.
// STRUCTURE
// - Shared package segasys1_pkg:
//   - SPRCOLL_AW=10;
//   - summary address bit index = 10;
//   - FSM typedef {ST_INIT, ST_RUN}.
// - Sub-module sprcoll_setq: sync FIFO, QDEPTH x AW.
//   - Ports: push (1 or 2 entries), pop, head, count, full2/full1, flush.
// - RAM: inferred 1024x1 with one write port and one registered read port.
// TESTING
// - Reset: release RSTn.
//   - busy stays 1 for 1024 clks, then 0.
//   - Reading every entry returns 00.
//   - Summary reads 00.
// - Single event: sprcoll=1 for 3 clks, ad=0x2A5.
//   - Summary read = 01.
//   - Entry 0x2A5 = 01; entry 0x2A4 = 00.
//   - Write 0x2A5, then read it = 00.
// - Overflow: QDEPTH+1 events, 2 clks apart, while CPU writes a matrix entry every clk (pops stalled).
//   - Summary = 03; the last event's entry = 00.
//   - Summary write, then read = 00.
// - Race: the CPU clear of 0x013 and the event for 0x013 land on the same clk.
//   - Entry 0x013 = 01.
//   - An event on the same clk as a summary clear gives summary = 01.
// - SYM_EN build: event ad=0x0C3 (a=6, b=3).
//   - Entries 0x0C3 and 0x066 = 01.
//   - Event ad=0x0A5 (a=b=5) leaves only 0x0A5 set.
//   - Without SYM_EN, 0x066 = 00.
// - Reset mid-run: assert RSTn low with 3 queued sets.
//   - busy=1 again; the queue is empty.
//   - After the sweep, all entries are 00.

Source files
------------

// File: rtl/segasys1_pkg.sv
// Shared definitions for the System 1 sprite-collision storage block.
package segasys1_pkg;

    localparam int SPRCOLL_AW = 10;
    // cpu_ad bit that selects the summary/status location instead of a matrix entry
    localparam int SUM_BIT    = 10;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } sprcoll_state_t;

    // Source of the data currently presented on cpu_dout
    typedef enum logic [1:0] {
        RD_NONE,
        RD_MAT,
        RD_SUM
    } rd_kind_t;

endpackage

// File: rtl/sprcoll_setq.sv
// Set-request queue: synchronous FIFO of matrix addresses awaiting a write of 1.
// Accepts one or two entries per clock; the caller guarantees room via full1/full2.
module sprcoll_setq #(
    parameter  int QDEPTH = 4,
    parameter  int AW     = 10,
    localparam int PW     = $clog2(QDEPTH),
    localparam int CW     = PW + 1
) (
    input  logic          VCLKx4,
    input  logic          RSTn,
    input  logic          flush,
    input  logic          push,
    input  logic          push2,
    input  logic [AW-1:0] din0,
    input  logic [AW-1:0] din1,
    input  logic          pop,
    output logic [AW-1:0] head,
    output logic [CW-1:0] count,
    output logic          full1,
    output logic          full2
);

    logic [AW-1:0] mem [0:QDEPTH-1];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] n_in;
    logic [CW-1:0] n_out;

    assign n_in  = push ? (push2 ? CW'(2) : CW'(1)) : '0;
    assign n_out = pop ? CW'(1) : '0;

    // Entry storage; second entry of a pair goes in the slot after the first
    always_ff @(posedge VCLKx4) begin
        if (push) begin
            mem[wr_ptr] <= din0;
            if (push2) mem[wr_ptr + PW'(1)] <= din1;
        end
    end

    // Pointers and occupancy; push and pop in the same clock net out
    always_ff @(posedge VCLKx4 or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (push2 ? PW'(2) : PW'(1));
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count_q <= count_q + n_in - n_out;
        end
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;
    assign full1 = (count_q == CW'(QDEPTH));
    assign full2 = (count_q >= CW'(QDEPTH - 1));

endmodule

// File: rtl/segasys1_sprcoll_ram.sv
// Sprite-collision matrix (1024 x 1) plus summary/overflow flags, read and
// cleared through the CPU collision window. Renderer strobes are queued and
// written as 1s whenever the CPU is not using the single write port.
// Build option SPRCOLL_SYM_EN: each event also sets the mirrored entry {b,a}.
//
// state   | meaning
// ST_INIT | sweeping zeros into the matrix, busy=1, bus and renderer ignored
// ST_RUN  | normal operation
module segasys1_sprcoll_ram
    import segasys1_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int AW     = SPRCOLL_AW
) (
    input  logic          VCLKx4,
    input  logic          RSTn,
    input  logic          sprcoll,
    input  logic [AW-1:0] sprcoll_ad,
    input  logic          cpu_cs,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [10:0]   cpu_ad,
    output logic [7:0]    cpu_dout,
    output logic          busy
);

    localparam int QCW = $clog2(QDEPTH) + 1;

    sprcoll_state_t state_q, state_d;
    logic [AW-1:0]  sweep_q;
    logic           running;

    logic           sprcoll_q;
    logic           evt;
    logic           accept;
    logic           q_push;
    logic           q_push2;
    logic [AW-1:0]  q_din1;
    logic           q_pop;
    logic [AW-1:0]  q_head;
    logic [QCW-1:0] q_count;
    logic           q_full1;
    logic           q_full2;

    logic           cpu_mat_wr;
    logic           cpu_sum_wr;
    logic           cpu_mat_rd;
    logic           cpu_sum_rd;

    logic           summary;
    logic           ovf;
    rd_kind_t       rd_kind_q;
    logic [1:0]     sum_q;

    logic           mem [0:(2**AW)-1];
    logic           ram_q;
    logic           ram_we;
    logic [AW-1:0]  ram_wa;
    logic           ram_wd;

    // State register and sweep address
    always_ff @(posedge VCLKx4 or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) sweep_q <= sweep_q + AW'(1);
        end
    end

    // Next state: leave INIT on the clock that writes the last address
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            ST_INIT: begin
                busy = 1'b1;
                if (sweep_q == {AW{1'b1}}) state_d = ST_RUN;
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    assign running    = (state_q == ST_RUN);
    assign cpu_mat_wr = running & cpu_cs & cpu_wr & ~cpu_ad[SUM_BIT];
    assign cpu_sum_wr = running & cpu_cs & cpu_wr &  cpu_ad[SUM_BIT];
    assign cpu_mat_rd = running & cpu_cs & cpu_rd & ~cpu_ad[SUM_BIT];
    assign cpu_sum_rd = running & cpu_cs & cpu_rd &  cpu_ad[SUM_BIT];

    assign evt = running & sprcoll & ~sprcoll_q;

`ifdef SPRCOLL_SYM_EN
    logic [AW/2-1:0] ad_a;
    logic [AW/2-1:0] ad_b;
    logic            sym_pair;

    assign ad_a     = sprcoll_ad[AW-1:AW/2];
    assign ad_b     = sprcoll_ad[AW/2-1:0];
    assign sym_pair = (ad_a != ad_b);
    // A mirrored pair is all-or-nothing, so it needs two free slots
    assign accept   = sym_pair ? ~q_full2 : ~q_full1;
    assign q_push2  = evt & accept & sym_pair;
    assign q_din1   = {ad_b, ad_a};
`else
    logic q_unused;

    assign q_unused = q_full2;
    assign accept   = ~q_full1;
    assign q_push2  = 1'b0;
    assign q_din1   = sprcoll_ad;
`endif

    assign q_push = evt & accept;
    assign q_pop  = running & ~cpu_mat_wr & (q_count != '0);

    sprcoll_setq #(
        .QDEPTH (QDEPTH),
        .AW     (AW)
    ) u_setq (
        .VCLKx4 (VCLKx4),
        .RSTn   (RSTn),
        .flush  (~running),
        .push   (q_push),
        .push2  (q_push2),
        .din0   (sprcoll_ad),
        .din1   (q_din1),
        .pop    (q_pop),
        .head   (q_head),
        .count  (q_count),
        .full1  (q_full1),
        .full2  (q_full2)
    );

    // Write-port arbitration: sweep, then CPU clear, then queued set
    always_comb begin
        ram_we = 1'b0;
        ram_wa = cpu_ad[AW-1:0];
        ram_wd = 1'b0;
        if (!running) begin
            ram_we = 1'b1;
            ram_wa = sweep_q;
        end else if (cpu_mat_wr) begin
            ram_we = 1'b1;
        end else if (q_pop) begin
            ram_we = 1'b1;
            ram_wa = q_head;
            ram_wd = 1'b1;
        end
    end

    // Matrix RAM; read sees the pre-write value on a same-clock collision
    always_ff @(posedge VCLKx4) begin
        if (ram_we) mem[ram_wa] <= ram_wd;
        if (cpu_mat_rd) ram_q <= mem[cpu_ad[AW-1:0]];
    end

    // Edge detect, flags and read-source tracking; an event beats a CPU clear
    always_ff @(posedge VCLKx4 or negedge RSTn) begin
        if (!RSTn) begin
            sprcoll_q <= 1'b0;
            summary   <= 1'b0;
            ovf       <= 1'b0;
            rd_kind_q <= RD_NONE;
            sum_q     <= 2'b00;
        end else begin
            sprcoll_q <= sprcoll;
            if (evt)             summary <= 1'b1;
            else if (cpu_sum_wr) summary <= 1'b0;
            if (evt && !accept)  ovf <= 1'b1;
            else if (cpu_sum_wr) ovf <= 1'b0;
            if (cpu_cs && cpu_rd) begin
                if (!running)              rd_kind_q <= RD_NONE;
                else if (cpu_ad[SUM_BIT])  rd_kind_q <= RD_SUM;
                else                       rd_kind_q <= RD_MAT;
            end
            if (cpu_sum_rd) sum_q <= {ovf, summary};
        end
    end

    // Read data holds until the next read replaces its source
    always_comb begin
        cpu_dout = 8'h00;
        case (rd_kind_q)
            RD_MAT:  cpu_dout = {7'b0, ram_q};
            RD_SUM:  cpu_dout = {6'b0, sum_q};
            default: cpu_dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_segasys1_sprcoll_ram.sv
// Directed bench for segasys1_sprcoll_ram; read expectations go through a scoreboard queue.
module tb_segasys1_sprcoll_ram;

    localparam int QDEPTH = 4;
    localparam logic [10:0] SUM_AD = 11'h400;

    logic        VCLKx4 = 1'b0;
    logic        RSTn = 1'b0;
    logic        sprcoll = 1'b0;
    logic [9:0]  sprcoll_ad = '0;
    logic        cpu_cs = 1'b0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [10:0] cpu_ad = '0;
    logic [7:0]  cpu_dout;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    string      tag_q[$];

    segasys1_sprcoll_ram #(.QDEPTH(QDEPTH), .AW(10)) dut (
        .VCLKx4     (VCLKx4),
        .RSTn       (RSTn),
        .sprcoll    (sprcoll),
        .sprcoll_ad (sprcoll_ad),
        .cpu_cs     (cpu_cs),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_ad     (cpu_ad),
        .cpu_dout   (cpu_dout),
        .busy       (busy)
    );

    always #5 VCLKx4 = ~VCLKx4;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic sb_compare();
        logic [7:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, cpu_dout, e);
    endtask

    task automatic cpu_read(input logic [10:0] a, input logic [7:0] e, input string t);
        @(negedge VCLKx4);
        cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_ad = a;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge VCLKx4); #1;
        cpu_cs = 1'b0; cpu_rd = 1'b0;
        sb_compare();
    endtask

    task automatic cpu_write(input logic [10:0] a);
        @(negedge VCLKx4);
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_ad = a;
        @(posedge VCLKx4); #1;
        cpu_cs = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic pulse(input logic [9:0] ad, input int len);
        @(negedge VCLKx4);
        sprcoll = 1'b1; sprcoll_ad = ad;
        repeat (len) @(negedge VCLKx4);
        sprcoll = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge VCLKx4);
        #1;
    endtask

    task automatic wait_sweep(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(posedge VCLKx4); #1;
            n++;
        end
        n_chk++;
        assert (n == 1024) else begin
            n_fail++;
            $error("FAIL %s: busy clocks observed %0d expected 1024", tag, n);
        end
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 1024; i++)
            cpu_read(11'(i), 8'h00, $sformatf("%s_%03h", tag, i));
    endtask

    initial begin
        // Reset state
        #23;
        check("rst_busy", {7'b0, busy}, 8'h01);
        check("rst_dout", cpu_dout, 8'h00);
        @(negedge VCLKx4);
        RSTn = 1'b1;
        wait_sweep("init_sweep");
        check("busy_low", {7'b0, busy}, 8'h00);
        read_all("init_entry");
        cpu_read(SUM_AD, 8'h00, "init_summary");

        // Single multi-clock event
        pulse(10'h2A5, 3);
        idle(3);
        cpu_read(SUM_AD, 8'h01, "single_summary");
        cpu_read(11'h2A5, 8'h01, "single_entry");
        idle(3);
        check("dout_hold", cpu_dout, 8'h01);
        cpu_read(11'h2A4, 8'h00, "single_neighbor");
        cpu_write(11'h2A5);
        cpu_read(11'h2A5, 8'h00, "single_cleared");
        cpu_write(SUM_AD);
        cpu_read(SUM_AD, 8'h00, "single_sum_clr");

        // Overflow with pops stalled by back-to-back CPU clears
        fork
            begin
                repeat (12) begin
                    @(negedge VCLKx4);
                    cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_ad = 11'h3FF;
                end
                @(negedge VCLKx4);
                cpu_cs = 1'b0; cpu_wr = 1'b0;
            end
            begin
                for (int i = 0; i <= QDEPTH; i++) begin
                    @(negedge VCLKx4);
                    sprcoll = 1'b1; sprcoll_ad = 10'(10'h100 + i);
                    @(negedge VCLKx4);
                    sprcoll = 1'b0;
                end
            end
        join
        idle(8);
        cpu_read(SUM_AD, 8'h03, "ovf_summary");
        cpu_read(11'h104, 8'h00, "ovf_dropped");
        for (int i = 0; i < QDEPTH; i++)
            cpu_read(11'(11'h100 + i), 8'h01, $sformatf("ovf_kept_%0d", i));
        cpu_write(SUM_AD);
        cpu_read(SUM_AD, 8'h00, "ovf_sum_clr");

        // Race: clear and set of the same entry on one clock
        @(negedge VCLKx4);
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_ad = 11'h013;
        sprcoll = 1'b1; sprcoll_ad = 10'h013;
        @(negedge VCLKx4);
        cpu_cs = 1'b0; cpu_wr = 1'b0; sprcoll = 1'b0;
        idle(3);
        cpu_read(11'h013, 8'h01, "race_entry");
        cpu_write(SUM_AD);
        cpu_read(SUM_AD, 8'h00, "race_sum_pre");
        @(negedge VCLKx4);
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_ad = SUM_AD;
        sprcoll = 1'b1; sprcoll_ad = 10'h020;
        @(negedge VCLKx4);
        cpu_cs = 1'b0; cpu_wr = 1'b0; sprcoll = 1'b0;
        idle(2);
        cpu_read(SUM_AD, 8'h01, "race_summary");

        // Symmetric-set option
        pulse(10'h0C3, 1);
        idle(4);
        cpu_read(11'h0C3, 8'h01, "sym_direct");
`ifdef SPRCOLL_SYM_EN
        cpu_read(11'h066, 8'h01, "sym_mirror");
`else
        cpu_read(11'h066, 8'h00, "sym_mirror");
`endif
        pulse(10'h0A5, 1);
        idle(4);
        cpu_read(11'h0A5, 8'h01, "sym_diag");

        // Reset mid-run with three sets queued
        fork
            begin
                repeat (8) begin
                    @(negedge VCLKx4);
                    cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_ad = 11'h3FF;
                end
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge VCLKx4);
                    sprcoll = 1'b1; sprcoll_ad = 10'(10'h200 + i);
                    @(negedge VCLKx4);
                    sprcoll = 1'b0;
                end
            end
        join
        #1;
        RSTn = 1'b0;
        cpu_cs = 1'b0; cpu_wr = 1'b0; sprcoll = 1'b0;
        idle(2);
        check("midrst_busy", {7'b0, busy}, 8'h01);
        check("midrst_dout", cpu_dout, 8'h00);
        @(negedge VCLKx4);
        RSTn = 1'b1;
        wait_sweep("midrst_sweep");
        idle(4);
        cpu_read(SUM_AD, 8'h00, "midrst_summary");
        read_all("midrst_entry");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
